fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 164 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall logic for an in-order pipeline that
// tracks the EX instruction plus DEPTH older post-EX stages.

module fwd_hazard_unit_chk #(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SW         = 2
) (
    input  logic                    rst_i,
    input  logic [DEPTH:0]          load_i,
    input  logic [NUM_SRC*SW-1:0]   fwd_sel_i
);

    function automatic logic ready_ok(input logic [SW-1:0] sel, input logic [DEPTH:0] ld);
        int s;
        s = int'(sel);
        if (s == 0 || s > DEPTH) begin
            return 1'b1;
        end else begin
            return s >= (ld[s] ? LOAD_STAGE : 1);
        end
    endfunction

    // A forwarding source must already hold its result when EX consumes it.
    always_comb begin
        for (int j = 0; j < NUM_SRC; j++) begin
            assert (rst_i || ready_ok(fwd_sel_i[j*SW +: SW], load_i));
        end
    end

endmodule

module fwd_hazard_unit #(
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int AW         = 5,
    parameter int CNT_W      = 16,
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    id_valid_i,
    input  logic [NUM_SRC*AW-1:0]   id_rs_i,
    input  logic [NUM_SRC-1:0]      id_rs_used_i,
    input  logic [AW-1:0]           id_rd_i,
    input  logic                    id_regwrite_i,
    input  logic                    id_load_i,
    input  logic                    flush_i,
    input  logic                    hold_i,
    output logic                    stall_o,
    output logic [NUM_SRC*SW-1:0]   fwd_sel_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    // Entry 0 is EX; entry k is the k-th stage after EX.
    logic [DEPTH:0]             valid_q, valid_d;
    logic [DEPTH:0]             regwr_q, regwr_d;
    logic [DEPTH:0]             load_q, load_d;
    logic [DEPTH:0][AW-1:0]     rd_q, rd_d;
    logic [NUM_SRC*AW-1:0]      ex_rs_q, ex_rs_d;
    logic [NUM_SRC-1:0]         ex_used_q, ex_used_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic                       stall_s;
    logic                       load_en_s;
    logic [NUM_SRC-1:0]         raw_s;
    logic [NUM_SRC*SW-1:0]      fwd_sel_s;

    function automatic logic is_match(input logic v, input logic w,
                                      input logic [AW-1:0] rd, input logic [AW-1:0] a);
        return v & w & (rd == a) & (a != {AW{1'b0}});
    endfunction

    // Scanning oldest to youngest lets the youngest matching writer win.
    function automatic logic [SW-1:0] fwd_stage(input logic [AW-1:0] a,
                                                input logic [DEPTH:0] v,
                                                input logic [DEPTH:0] w,
                                                input logic [DEPTH:0][AW-1:0] rd);
        logic [SW-1:0] sel;
        sel = {SW{1'b0}};
        for (int s = DEPTH; s >= 1; s--) begin
            sel = is_match(v[s], w[s], rd[s], a) ? SW'(s) : sel;
        end
        return sel;
    endfunction

    function automatic logic late_result(input logic [AW-1:0] a,
                                         input logic [DEPTH:0] v,
                                         input logic [DEPTH:0] w,
                                         input logic [DEPTH:0] ld,
                                         input logic [DEPTH:0][AW-1:0] rd);
        logic late;
        late = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            late = is_match(v[s], w[s], rd[s], a) ? (s + 1 < (ld[s] ? LOAD_STAGE : 1)) : late;
        end
        return late;
    endfunction

    // Hazard detection for ID sources and forward selection for EX sources.
    always_comb begin
        raw_s     = {NUM_SRC{1'b0}};
        fwd_sel_s = {(NUM_SRC*SW){1'b0}};
        for (int j = 0; j < NUM_SRC; j++) begin
            raw_s[j] = id_rs_used_i[j] &
                       late_result(id_rs_i[j*AW +: AW], valid_q, regwr_q, load_q, rd_q);
            fwd_sel_s[j*SW +: SW] = (valid_q[0] & ex_used_q[j]) ?
                                    fwd_stage(ex_rs_q[j*AW +: AW], valid_q, regwr_q, rd_q) :
                                    {SW{1'b0}};
        end
        stall_s = id_valid_i & ~flush_i & (|raw_s);
    end

    // Next state: shift the tracker, admit ID into EX or insert a bubble.
    always_comb begin
        load_en_s = id_valid_i & ~stall_s & ~flush_i;
        valid_d   = {valid_q[DEPTH-1:0], load_en_s};
        regwr_d   = {regwr_q[DEPTH-1:0], id_regwrite_i};
        load_d    = {load_q[DEPTH-1:0], id_load_i};
        rd_d      = {rd_q[DEPTH-1:0], id_rd_i};
        ex_rs_d   = id_rs_i;
        ex_used_d = id_rs_used_i;
        cnt_d     = (stall_s && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State registers; a freeze holds every entry and the counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= {(DEPTH+1){1'b0}};
            regwr_q   <= {(DEPTH+1){1'b0}};
            load_q    <= {(DEPTH+1){1'b0}};
            rd_q      <= {((DEPTH+1)*AW){1'b0}};
            ex_rs_q   <= {(NUM_SRC*AW){1'b0}};
            ex_used_q <= {NUM_SRC{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
        end else if (!hold_i) begin
            valid_q   <= valid_d;
            regwr_q   <= regwr_d;
            load_q    <= load_d;
            rd_q      <= rd_d;
            ex_rs_q   <= ex_rs_d;
            ex_used_q <= ex_used_d;
            cnt_q     <= cnt_d;
        end
    end

    assign stall_o     = stall_s;
    assign fwd_sel_o   = fwd_sel_s;
    assign stall_cnt_o = cnt_q;

    fwd_hazard_unit_chk #(
        .NUM_SRC    (NUM_SRC),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE),
        .SW         (SW)
    ) u_chk (
        .rst_i      (rst_i),
        .load_i     (load_q),
        .fwd_sel_i  (fwd_sel_s)
    );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default build plus a CNT_W=4 build
// sharing the same stimulus for counter saturation.

module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_used;
    logic [4:0]  id_rd;
    logic        id_rw;
    logic        id_ld;
    logic        flush;
    logic        hold;
    logic        stall, stall4;
    logic [3:0]  fwd, fwd4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rs_used_i  (id_used),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_rw),
        .id_load_i     (id_ld),
        .flush_i       (flush),
        .hold_i        (hold),
        .stall_o       (stall),
        .fwd_sel_o     (fwd),
        .stall_cnt_o   (cnt)
    );

    fwd_hazard_unit #(.CNT_W(4)) dut4 (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rs_used_i  (id_used),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_rw),
        .id_load_i     (id_ld),
        .flush_i       (flush),
        .hold_i        (hold),
        .stall_o       (stall4),
        .fwd_sel_o     (fwd4),
        .stall_cnt_o   (cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                          input logic [4:0] rd, input logic rw, input logic ld);
        id_valid = 1'b1;
        id_rs    = {rs1, rs0};
        id_used  = used;
        id_rd    = rd;
        id_rw    = rw;
        id_ld    = ld;
    endtask

    task automatic nop();
        id_valid = 1'b0;
        id_rs    = 10'd0;
        id_used  = 2'b00;
        id_rd    = 5'd0;
        id_rw    = 1'b0;
        id_ld    = 1'b0;
    endtask

    task automatic idle(input int n);
        nop();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0; nop();
        tick(); tick();
        chk("rst_cnt", cnt, 0);
        chk("rst_cnt4", cnt4, 0);
        rst = 1'b0; #1;
        chk("rst_fwd", fwd, 0);
        chk("rst_stall", stall, 0);

        // ALU x5 then x6 = x5 + x1
        id_set(5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0); #1;
        chk("alu_first_stall", stall, 0); tick();
        id_set(5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0); #1;
        chk("alu_dep_stall", stall, 0);
        chk("alu_fwd_before", fwd, 0); tick();
        nop(); #1;
        chk("alu_fwd", fwd, 4'b0001); tick();
        chk("alu_fwd_bubble", fwd, 0);
        idle(3);

        // load x5 then use x5
        id_set(5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1); #1;
        chk("ld_first_stall", stall, 0); tick();
        id_set(5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0); #1;
        chk("ld_use_stall", stall, 1); tick();
        chk("ld_use_cnt", cnt, 1);
        chk("ld_use_stall_clr", stall, 0);
        chk("ld_use_bubble_fwd", fwd, 0); tick();
        nop(); #1;
        chk("ld_use_fwd", fwd, 4'b0010);
        chk("ld_use_cnt_hold", cnt, 1);
        idle(3);

        // x7, x7, then x7 + x7: youngest writer wins
        id_set(5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 1'b0); tick();
        id_set(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0); tick();
        id_set(5'd7, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0); #1;
        chk("yng_stall", stall, 0); tick();
        nop(); #1;
        chk("yng_fwd", fwd, 4'b0101);
        idle(3);

        // writes to x0 are never forwarded nor stalled on
        id_set(5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0); tick();
        id_set(5'd0, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0); #1;
        chk("x0_stall", stall, 0); tick();
        nop(); #1;
        chk("x0_fwd", fwd, 0);
        id_set(5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1); tick();
        id_set(5'd0, 5'd0, 2'b01, 5'd9, 1'b1, 1'b0); #1;
        chk("x0_ld_stall", stall, 0); tick();
        idle(3);

        // flush during load-use: the flushed load x6 must not enter EX
        id_set(5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1); tick();
        id_set(5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b1); flush = 1'b1; #1;
        chk("flush_stall", stall, 0); tick();
        flush = 1'b0;
        id_set(5'd6, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0); #1;
        chk("flush_bubble", stall, 0);
        chk("flush_cnt", cnt, 1); tick();
        idle(3);

        // reset mid-stall, asserted together with hold
        id_set(5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1); tick();
        id_set(5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0); #1;
        chk("rst_mid_pre", stall, 1);
        rst = 1'b1; hold = 1'b1; tick();
        rst = 1'b0; hold = 1'b0; #1;
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_cnt", cnt, 0);
        chk("rst_mid_cnt4", cnt4, 0); tick();
        idle(3);

        // load-use under a 3-cycle hold
        id_set(5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1); tick();
        id_set(5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0); hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_stall", stall, 1); tick();
            chk("hold_cnt", cnt, 0);
        end
        hold = 1'b0; #1;
        chk("hold_rel_stall", stall, 1); tick();
        chk("hold_rel_cnt", cnt, 1);
        chk("hold_rel_clr", stall, 0); tick();
        nop(); #1;
        chk("hold_fwd", fwd, 4'b0010);
        idle(3);

        // saturation of the 4-bit counter over 16 load-use stalls
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            id_set(5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1); tick();
            id_set(5'd5, 5'd0, 2'b01, 5'd7, 1'b1, 1'b0); tick();
            chk("sat_cnt16", cnt, i);
            chk("sat_cnt4", cnt4, (i > 15) ? 15 : i);
            tick();
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
